v_alu_pipe: RTL and testbench

Pipelined, lane-parametrised vector ALU with valid/ready handshakes on input and output. It processes one VALU_OP_W_MAX-bit beat per cycle, holding 8-, 16- or 32-bit elements. It adds multi-beat reduction (sum/max) through an internal accumulator FSM and optional signed saturating arithmetic. It sits between the vector register read stage and the writeback arbiter in the coprocessor datapath.

---
 rtl/v_alu_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_v_alu_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_alu_pipe.sv
// v_alu_pipe: two-stage vector ALU (8/16/32-bit elements) with multi-beat sum/max reduction.
// Optional macro VALU_SAT_EN enables signed saturating VSADD/VSSUB and a live sat_flag.

module v_alu_pipe #(
  parameter int VALU_OP_W_MAX = 128
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               op_instr,
  input  logic [1:0]               vsew,
  input  logic [VALU_OP_W_MAX-1:0] op_A,
  input  logic [VALU_OP_W_MAX-1:0] op_B,
  input  logic                     red_first,
  input  logic                     red_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VALU_OP_W_MAX-1:0] result,
  output logic                     sat_flag,
  output logic                     busy
);
  localparam int NUM_W32 = VALU_OP_W_MAX / 32;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLL    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_MIN    = 4'd8;
  localparam logic [3:0] OP_MAX    = 4'd9;
  localparam logic [3:0] OP_MINU   = 4'd10;
  localparam logic [3:0] OP_MAXU   = 4'd11;
  localparam logic [3:0] OP_SADD   = 4'd12;
  localparam logic [3:0] OP_SSUB   = 4'd13;
  localparam logic [3:0] OP_REDSUM = 4'd14;
  localparam logic [3:0] OP_REDMAX = 4'd15;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RED_ACC = 1'b1;

  function automatic logic [5:0] sew_width(input logic [1:0] s);
    case (s)
      2'd0:    return 6'd8;
      2'd1:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [31:0] sew_mask(input logic [5:0] w);
    return (w == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic signed [31:0] sext(input logic [31:0] x, input logic [5:0] w);
    logic [5:0] pad;
    pad = 6'd32 - w;
    return $signed(x << pad) >>> pad;
  endfunction

  // One element held zero-extended in 32 bits; returns {overflow, masked result}.
  function automatic logic [32:0] elem_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [5:0] w);
    logic [31:0] mask, am, bm, res;
    logic signed [31:0] sa, sb;
    logic [4:0] amt;
    logic sat;
`ifdef VALU_SAT_EN
    logic signed [32:0] ssum, smax, smin;
`endif
    mask = sew_mask(w);
    am   = a & mask;
    bm   = b & mask;
    sa   = sext(a, w);
    sb   = sext(b, w);
    amt  = a[4:0] & 5'(w - 6'd1);
    res  = '0;
    sat  = 1'b0;
    case (op)
      OP_ADD:  res = am + bm;
      OP_SUB:  res = am - bm;
      OP_AND:  res = am & bm;
      OP_OR:   res = am | bm;
      OP_XOR:  res = am ^ bm;
      OP_SLL:  res = bm << amt;
      OP_SRL:  res = bm >> amt;
      OP_SRA:  res = 32'(sb >>> amt);
      OP_MIN:  res = (sa < sb) ? am : bm;
      OP_MAX:  res = (sa > sb) ? am : bm;
      OP_MINU: res = (am < bm) ? am : bm;
      OP_MAXU: res = (am > bm) ? am : bm;
      OP_SADD, OP_SSUB: begin
`ifdef VALU_SAT_EN
        smax = $signed({1'b0, mask >> 1});
        smin = -smax - 33'sd1;
        ssum = (op == OP_SADD) ? (33'(sa) + 33'(sb)) : (33'(sa) - 33'(sb));
        if (ssum > smax) begin
          res = smax[31:0];
          sat = 1'b1;
        end else if (ssum < smin) begin
          res = smin[31:0];
          sat = 1'b1;
        end else begin
          res = ssum[31:0];
        end
`else
        res = (op == OP_SADD) ? (am + bm) : (am - bm);
`endif
      end
      default: res = '0;
    endcase
    return {sat, res & mask};
  endfunction

  // Splits a 32-bit word into SEW elements; results are already masked so OR-merge is safe.
  function automatic logic [32:0] word_op(input logic [3:0] op, input logic [1:0] sew,
                                          input logic [31:0] aw, input logic [31:0] bw);
    logic [32:0] r;
    logic [31:0] acc;
    logic s;
    acc = '0;
    s   = 1'b0;
    case (sew)
      2'd0: for (int j = 0; j < 4; j++) begin
        r   = elem_op(op, {24'h0, aw[j*8 +: 8]}, {24'h0, bw[j*8 +: 8]}, 6'd8);
        acc = acc | (r[31:0] << (8 * j));
        s   = s | r[32];
      end
      2'd1: for (int j = 0; j < 2; j++) begin
        r   = elem_op(op, {16'h0, aw[j*16 +: 16]}, {16'h0, bw[j*16 +: 16]}, 6'd16);
        acc = acc | (r[31:0] << (16 * j));
        s   = s | r[32];
      end
      2'd2: begin
        r   = elem_op(op, aw, bw, 6'd32);
        acc = r[31:0];
        s   = r[32];
      end
      default: ;
    endcase
    return {s, acc};
  endfunction

  function automatic logic [31:0] fold_step(input logic is_max, input logic [31:0] acc,
                                            input logic [31:0] e, input logic [5:0] w);
    logic [31:0] mask;
    mask = sew_mask(w);
    if (is_max) return (sext(e, w) > sext(acc, w)) ? (e & mask) : (acc & mask);
    return (acc + e) & mask;
  endfunction

  logic                     s1_valid_q, s1_valid_d;
  logic [3:0]               s1_op_q;
  logic [1:0]               s1_sew_q;
  logic [VALU_OP_W_MAX-1:0] s1_a_q, s1_b_q;
  logic                     s1_first_q, s1_last_q, s1_red_q;
  logic                     s2_valid_q, s2_valid_d;
  logic [VALU_OP_W_MAX-1:0] s2_res_q, s2_res_d;
  logic                     s2_sat_q, s2_sat_d;
  logic [31:0]              acc_q, acc_d;
  logic [0:0]               state_q, state_d;

  logic                     advance, s1_en, s1_seed;
  logic [VALU_OP_W_MAX-1:0] elem_res;
  logic                     elem_sat;
  logic [32:0]              word_r;
  logic [31:0]              fold_acc;
  logic [5:0]               red_w;

  assign advance  = out_ready || !s2_valid_q;
  assign s1_en    = advance || !s1_valid_q;
  assign in_ready = nrst && s1_en;
  assign s1_seed  = (state_q == ST_IDLE) || s1_first_q;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin : compute
    elem_res = '0;
    elem_sat = 1'b0;
    word_r   = '0;
    for (int k = 0; k < NUM_W32; k++) begin
      word_r              = word_op(s1_op_q, s1_sew_q, s1_a_q[k*32 +: 32], s1_b_q[k*32 +: 32]);
      elem_res[k*32 +: 32] = word_r[31:0];
      elem_sat            = elem_sat | word_r[32];
    end
    red_w    = sew_width(s1_sew_q);
    fold_acc = s1_seed ? (s1_a_q[31:0] & sew_mask(red_w)) : acc_q;
    case (s1_sew_q)
      2'd0: for (int i = 0; i < NUM_W32 * 4; i++)
        fold_acc = fold_step(s1_op_q == OP_REDMAX, fold_acc, {24'h0, s1_b_q[i*8 +: 8]}, 6'd8);
      2'd1: for (int i = 0; i < NUM_W32 * 2; i++)
        fold_acc = fold_step(s1_op_q == OP_REDMAX, fold_acc, {16'h0, s1_b_q[i*16 +: 16]}, 6'd16);
      default: for (int i = 0; i < NUM_W32; i++)
        fold_acc = fold_step(s1_op_q == OP_REDMAX, fold_acc, s1_b_q[i*32 +: 32], 6'd32);
    endcase
  end

  always_comb begin : next_state
    s1_valid_d = s1_en ? in_valid : s1_valid_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_sat_d   = s2_sat_q;
    acc_d      = acc_q;
    state_d    = state_q;
    if (advance) begin
      // Non-final reduction beats fold into acc and vanish from the output stream.
      s2_valid_d = s1_valid_q && !(s1_red_q && !s1_last_q);
      if (s1_valid_q && s1_red_q) begin
        acc_d   = fold_acc;
        state_d = s1_last_q ? ST_IDLE : ST_RED_ACC;
        if (s1_last_q) begin
          s2_res_d       = '0;
          s2_res_d[31:0] = (s1_sew_q == 2'd3) ? 32'h0 : fold_acc;
          s2_sat_d       = 1'b0;
        end
      end else if (s1_valid_q) begin
        s2_res_d = elem_res;
        s2_sat_d = elem_sat;
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_sat_q   <= 1'b0;
      acc_q      <= '0;
      state_q    <= ST_IDLE;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_sat_q   <= s2_sat_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
    end
  end

  // NOTE: the S1 payload has no reset; s1_valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      s1_op_q    <= op_instr;
      s1_sew_q   <= vsew;
      s1_a_q     <= op_A;
      s1_b_q     <= op_B;
      s1_first_q <= red_first;
      s1_last_q  <= red_last;
      s1_red_q   <= (op_instr == OP_REDSUM) || (op_instr == OP_REDMAX);
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign sat_flag  = s2_sat_q;
  assign busy      = (state_q == ST_RED_ACC);

endmodule

// File: tb/tb_v_alu_pipe.sv
// Self-checking bench for v_alu_pipe: vector table, reductions, backpressure and reset,
// with a scoreboard queue of expected result beats.

module tb_v_alu_pipe;
  localparam int W = 128;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
  localparam logic [3:0] OP_MIN = 4'd8,  OP_MAX = 4'd9,  OP_MINU = 4'd10, OP_MAXU = 4'd11;
  localparam logic [3:0] OP_SADD = 4'd12, OP_SSUB = 4'd13, OP_REDSUM = 4'd14, OP_REDMAX = 4'd15;

`ifdef VALU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nrst, in_valid, in_ready, red_first, red_last;
  logic         out_valid, out_ready, sat_flag, busy;
  logic [3:0]   op_instr;
  logic [1:0]   vsew;
  logic [W-1:0] op_A, op_B, result;

  always #5 clk = ~clk;

  v_alu_pipe #(.VALU_OP_W_MAX(W)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .op_instr(op_instr), .vsew(vsew), .op_A(op_A), .op_B(op_B),
    .red_first(red_first), .red_last(red_last), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .sat_flag(sat_flag), .busy(busy)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         sat;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [1:0]   sew;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         exp_sat;
  } vec_t;

  exp_t   sb_q[$];
  vec_t   vecs[18];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] op, input logic [1:0] sew,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input logic exp_sat);
    vecs[i].op = op;  vecs[i].sew = sew; vecs[i].a = a; vecs[i].b = b;
    vecs[i].exp = exp; vecs[i].exp_sat = exp_sat;
  endtask

  // Drives one beat from a negedge, holds it until accepted, then withdraws it.
  task automatic send(input logic [3:0] op, input logic [1:0] sew, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic first, input logic last,
                      input logic push, input logic [W-1:0] exp_res, input logic exp_sat);
    int t;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; op_instr = op; vsew = sew; op_A = a; op_B = b;
    red_first = first; red_last = last;
    #1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 (op %0d)", op);
      in_valid = 1'b0;
    end else begin
      if (push) begin
        e.res = exp_res;
        e.sat = exp_sat;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    check("drain_empty", W'(sb_q.size()), W'(0));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (nrst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected no beat", result);
        end else begin
          e = sb_q.pop_front();
          check("sb_result", result, e.res);
          check("sb_sat", W'(sat_flag), W'(e.sat));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time got exhausted expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [W-1:0] bp_a[4];
  logic [W-1:0] bp_b;

  initial begin : stim
    set_vec(0,  OP_ADD,  2'd0, 128'h7F01FF80, 128'h01FF0180, 128'h80000000, 1'b0);
    set_vec(1,  OP_SUB,  2'd1, 128'h00000001, 128'h00010002, 128'hFFFFFFFF, 1'b0);
    set_vec(2,  OP_AND,  2'd2, 128'hF0F0F0F0, 128'hFF00FF00, 128'hF000F000, 1'b0);
    set_vec(3,  OP_OR,   2'd0, 128'h0F0F0000, 128'hF0000001, 128'hFF0F0001, 1'b0);
    set_vec(4,  OP_XOR,  2'd2, 128'hFFFF0000, 128'h0F0F0F0F, 128'hF0F00F0F, 1'b0);
    set_vec(5,  OP_SLL,  2'd0, 128'h09010803, 128'h8181FF11, 128'h0202FF88, 1'b0);
    set_vec(6,  OP_SRL,  2'd1, 128'h00110004, 128'h8000F000, 128'h40000F00, 1'b0);
    set_vec(7,  OP_SRA,  2'd1, 128'h00130001, 128'h80000010, 128'hF0000008, 1'b0);
    set_vec(8,  OP_MIN,  2'd0, 128'h807F01FF, 128'h7F800200, 128'h808001FF, 1'b0);
    set_vec(9,  OP_MAX,  2'd2, 128'h80000000, 128'h00000001, 128'h00000001, 1'b0);
    set_vec(10, OP_MINU, 2'd1, 128'h80000003, 128'h00010004, 128'h00010003, 1'b0);
    set_vec(11, OP_MAXU, 2'd0, 128'h807F01FF, 128'h7F800200, 128'h808002FF, 1'b0);
    set_vec(12, OP_ADD,  2'd3, 128'h0000FFFF, 128'h00000001, 128'h0, 1'b0);
    set_vec(13, OP_SADD, 2'd0, 128'h7F, 128'h01, SAT_EN ? 128'h7F : 128'h80, SAT_EN);
    set_vec(14, OP_SSUB, 2'd1, 128'h8000, 128'h0001, SAT_EN ? 128'h8000 : 128'h7FFF, SAT_EN);
    set_vec(15, OP_ADD,  2'd2, {4{32'hFFFFFFFF}}, {4{32'h00000001}}, 128'h0, 1'b0);
    set_vec(16, OP_SADD, 2'd2, {4{32'h7FFFFFFF}}, {4{32'h00000001}},
            SAT_EN ? {4{32'h7FFFFFFF}} : {4{32'h80000000}}, SAT_EN);
    set_vec(17, OP_SLL,  2'd2, {32'h0000003F, 96'h0}, {32'h00000003, 96'h0},
            {32'h80000000, 96'h0}, 1'b0);

    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_instr = '0; vsew = '0;
    op_A = '0; op_B = '0; red_first = 1'b0; red_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, W'(0));
    check("rst_sat", W'(sat_flag), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    nrst = 1'b1;
    #3;
    check("post_rst_in_ready", W'(in_ready), W'(1));

    // Latency: out_valid is low one edge after acceptance and high after the second.
    send(OP_ADD, 2'd0, 128'h7F01FF80, 128'h01FF0180, 1'b0, 1'b0, 1'b1, 128'h80000000, 1'b0);
    @(negedge clk);
    #3;
    check("lat_edge1_valid", W'(out_valid), W'(0));
    @(negedge clk);
    #3;
    check("lat_edge2_valid", W'(out_valid), W'(1));
    check("lat_edge2_result", result, 128'h80000000);
    drain();

    for (int i = 0; i < 18; i++)
      send(vecs[i].op, vecs[i].sew, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 1'b1,
           vecs[i].exp, vecs[i].exp_sat);
    drain();

    // Three-beat VREDSUM with an unrelated VAND slipped in mid-reduction.
    send(OP_REDSUM, 2'd2, 128'd5, {4{32'd1}}, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    send(OP_AND, 2'd2, 128'hF0F0F0F0, 128'hFF00FF00, 1'b0, 1'b0, 1'b1, 128'hF000F000, 1'b0);
    #3;
    check("red_busy_mid", W'(busy), W'(1));
    send(OP_REDSUM, 2'd2, 128'd99, {4{32'd1}}, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send(OP_REDSUM, 2'd2, 128'd77, {4{32'd1}}, 1'b0, 1'b1, 1'b0 | 1'b1, 128'd17, 1'b0);
    drain();
    check("red_busy_after", W'(busy), W'(0));

    // Single-beat byte sum wraps: 0xF0 + 16 = 0x100 -> 0x00.
    send(OP_REDSUM, 2'd0, 128'h1F0, {16{8'h01}}, 1'b1, 1'b1, 1'b1, 128'h0, 1'b0);
    // red_first in RED_ACC discards the 0x7000 partial max.
    send(OP_REDMAX, 2'd1, 128'h7000, {8{16'h0001}}, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    send(OP_REDMAX, 2'd1, 128'h8000, {8{16'hFFFF}}, 1'b1, 1'b1, 1'b1, 128'hFFFF, 1'b0);
    drain();

    // Backpressure: four VXOR beats against a stalled sink.
    bp_b = {4{32'h0F0F0F0F}};
    for (int i = 0; i < 4; i++) bp_a[i] = {4{8'(i + 1), 24'hA5A5A5}};
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(OP_XOR, 2'd2, bp_a[i], bp_b, 1'b0, 1'b0, 1'b1, bp_a[i] ^ bp_b, 1'b0);
      end
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("bp_in_ready_low", W'(in_ready), W'(0));
        check("bp_out_valid", W'(out_valid), W'(1));
        check("bp_hold_0", result, bp_a[0] ^ bp_b);
        for (int k = 1; k <= 2; k++) begin
          @(negedge clk);
          #3;
          check($sformatf("bp_hold_%0d", k), result, bp_a[0] ^ bp_b);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-reduction, then a lone red_last beat must reseed from A.
    send(OP_REDSUM, 2'd0, 128'h70, 128'h0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check("mid_red_busy", W'(busy), W'(1));
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #3;
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_result", result, W'(0));
    check("mid_rst_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    nrst = 1'b1;
    send(OP_REDMAX, 2'd0, 128'h80, {{14{8'h81}}, 8'hF0, 8'h05}, 1'b0, 1'b1, 1'b1,
         128'h05, 1'b0);
    drain();
    check("final_busy", W'(busy), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
